// File: rtl/sqsum_acc_acq_if.sv
// Converter/consumer bundle for sqsum_acc_acq.
// master: block side (drives soc, dav_, q); slave: converters + consumer.
interface sqsum_acc_acq_if #(
    parameter int W    = 8,
    parameter int NACC = 4
);
    localparam int QW = 2 * W + 2 + $clog2(NACC);

    logic          soc;
    logic          eocx;
    logic [W-1:0]  x;
    logic          eocy;
    logic [W-1:0]  y;
    logic          mode;
    logic          dav_;
    logic          rfd;
    logic [QW-1:0] q;

    modport master (
        output soc, dav_, q,
        input  eocx, x, eocy, y, mode, rfd
    );

    modport slave (
        input  soc, dav_, q,
        output eocx, x, eocy, y, mode, rfd
    );
endinterface

// File: rtl/sqsum_acc_acq.sv
// Dual-converter acquisition: accumulates NACC of (x+y)^2 or |x-y|^2.
// Ports: clock, reset_ (async, active-high), bus (sqsum_acc_acq_if.master).
module sqsum_acc_acq #(
    parameter int W    = 8,
    parameter int NACC = 4
) (
    input  logic clock,
    input  logic reset_,
    sqsum_acc_acq_if.master bus
);
    localparam int QW = 2 * W + 2 + $clog2(NACC);
    localparam int CW = (NACC > 1) ? $clog2(NACC) : 1;

    typedef enum logic [2:0] {
        START,
        WAIT_LO,
        WAIT_HI,
        CALC,
        WAIT_ACK,
        WAIT_REL
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          soc_r;
    logic          dav_r;
    logic          soc_nx;
    logic          dav_nx;

    logic [W-1:0]  xr;
    logic [W-1:0]  yr;
    logic          mode_r;
    logic [CW-1:0] cnt;
    logic [QW-1:0] acc;
    logic [QW-1:0] q_r;

    logic [W:0]     sum_xy;
    logic [W-1:0]   diff;
    logic [W:0]     opnd;
    logic [2*W+1:0] sq;
    logic [QW-1:0]  acc_sum;
    logic           last;
    logic           both_lo;
    logic           both_hi;

    assign both_lo = !bus.eocx && !bus.eocy;
    assign both_hi = bus.eocx && bus.eocy;
    assign last    = (cnt == CW'(NACC - 1));

    // Single-cycle square; |x-y| fits in W bits, x+y needs W+1.
    always_comb begin
        sum_xy  = {1'b0, xr} + {1'b0, yr};
        diff    = (xr >= yr) ? (xr - yr) : (yr - xr);
        opnd    = mode_r ? {1'b0, diff} : sum_xy;
        sq      = {{(W+1){1'b0}}, opnd} * {{(W+1){1'b0}}, opnd};
        acc_sum = acc + QW'(sq);
    end

    // State register (outputs registered alongside).
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state <= START;
            soc_r <= 1'b0;
            dav_r <= 1'b1;
        end else begin
            state <= state_nx;
            soc_r <= soc_nx;
            dav_r <= dav_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            START:    state_nx = WAIT_LO;
            WAIT_LO:  if (both_lo) state_nx = WAIT_HI;
            WAIT_HI:  if (both_hi) state_nx = CALC;
            CALC:     state_nx = last ? WAIT_ACK : WAIT_LO;
            WAIT_ACK: if (!bus.rfd) state_nx = WAIT_REL;
            WAIT_REL: if (bus.rfd) state_nx = WAIT_LO;
            default:  state_nx = START;
        endcase
    end

    // Output values for the state being entered, so the
    // registered outputs line up with the new state.
    always_comb begin
        soc_nx = (state_nx == WAIT_LO);
        dav_nx = (state_nx != WAIT_ACK);
    end

    // Datapath: sample capture, accumulation, delivery.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            xr     <= '0;
            yr     <= '0;
            mode_r <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            q_r    <= '0;
        end else begin
            if (state == WAIT_HI && both_hi) begin
                xr <= bus.x;
                yr <= bus.y;
                // mode is fixed for a whole output word
                if (cnt == '0) mode_r <= bus.mode;
            end
            if (state == CALC) begin
                if (last) begin
                    q_r <= acc_sum;
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.soc  = soc_r;
    assign bus.dav_ = dav_r;
    assign bus.q    = q_r;
endmodule
